// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: sponge modes, per-mode rate and domain byte,
// and the load-stage FSM state encoding.
package keccak_pkg;

    localparam int unsigned RATE_MAX = 1344;

    typedef enum logic [1:0] {
        MODE_SHAKE128 = 2'b00,
        MODE_SHAKE256 = 2'b01,
        MODE_SHA3_256 = 2'b10,
        MODE_SHA3_512 = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_HDR0,
        ST_HDR1,
        ST_LOAD,
        ST_PAD
    } load_state_t;

    // Rate in bytes for each mode.
    function automatic logic [7:0] rate_bytes(input mode_t m);
        logic [7:0] r;
        case (m)
            MODE_SHAKE128: r = 8'd168;
            MODE_SHAKE256: r = 8'd136;
            MODE_SHA3_256: r = 8'd136;
            default:       r = 8'd72;
        endcase
        return r;
    endfunction

    // Domain-separation byte for each mode.
    function automatic logic [7:0] domain_byte(input mode_t m);
        logic [7:0] d;
        case (m)
            MODE_SHAKE128, MODE_SHAKE256: d = 8'h1F;
            default:                      d = 8'h06;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_block_buf.sv
// One block buffer: rate-sized data plus mode, output size and last flag.
// Supports word writes, single-byte OR, commit (with final 0x80 pad) and clear.
module load_block_buf #(
    parameter int unsigned W         = 64,
    parameter int unsigned RATE_BITS = 1344
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc,
    input  logic [1:0]           mode_in,
    input  logic [31:0]          size_in,
    input  logic                 wr_en,
    input  logic [5:0]           wr_idx,
    input  logic [W-1:0]         wr_data,
    input  logic                 or_en,
    input  logic [7:0]           or_idx,
    input  logic [7:0]           or_byte,
    input  logic                 commit,
    input  logic                 last_in,
    input  logic                 clear,
    output logic [RATE_BITS-1:0] data,
    output logic [1:0]           mode,
    output logic [31:0]          size,
    output logic                 last,
    output logic                 busy,
    output logic                 valid
);
    import keccak_pkg::*;

    logic [7:0] pad_pos;

    // Byte index of the final pad bit for this buffer's mode.
    always_comb begin
        pad_pos = rate_bytes(mode_t'(mode)) - 8'd1;
    end

    // Buffer contents and status; clear wins over every other control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            mode  <= '0;
            size  <= '0;
            last  <= 1'b0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else if (clear) begin
            data  <= '0;
            mode  <= '0;
            size  <= '0;
            last  <= 1'b0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            if (alloc) begin
                busy <= 1'b1;
                mode <= mode_in;
                size <= size_in;
            end
            if (wr_en)
                data[32'(wr_idx) * W +: W] <= wr_data;
            if (or_en)
                data[{or_idx, 3'b000} +: 8] <= data[{or_idx, 3'b000} +: 8] | or_byte;
            if (commit) begin
                valid <= 1'b1;
                last  <= last_in;
                if (last_in)
                    data[{pad_pos, 3'b000} +: 8] <= data[{pad_pos, 3'b000} +: 8] | 8'h80;
            end
        end
    end

endmodule

// File: rtl/load_stage_mr.sv
// Multi-rate Keccak load stage: parses a 2-word header, packs message words
// into rate-sized blocks with domain padding, and hands blocks to the absorb
// stage through NUM_BUFS buffers.
// Build option: LOAD_BYTE_SWAP_EN byte-reverses every message word before storing.
module load_stage_mr #(
    parameter int unsigned W        = 64,
    parameter int unsigned NUM_BUFS = 2,
    parameter int unsigned RATE_MAX = 1344
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [W-1:0]        data_in,
    output logic                ready_out,
    output logic [RATE_MAX-1:0] block_out,
    output logic                block_valid,
    input  logic                block_ready,
    output logic                block_last,
    output logic [1:0]          block_mode,
    output logic [31:0]         output_size
);
    import keccak_pkg::*;

    localparam int unsigned BPW = W / 8;
    localparam int unsigned PW  = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;

    load_state_t         state, state_nx;
    logic                armed;
    mode_t               mode_q;
    logic [31:0]         size_q;
    logic [29:0]         remaining;
    logic [5:0]          widx, wpb;
    logic [PW-1:0]       cur, wr_ptr, rd_ptr, commit_idx, target;
    logic                cur_alloc, commit_pend, commit_last;
    logic                do_write, do_or, blk_end, msg_end, alloc;
    logic                have_buf, block_full, take_blk, hdr0_take, hdr1_take;
    logic [W-1:0]        swapped, wr_word;
    logic [7:0]          dom, pad_idx;

    logic [RATE_MAX-1:0] buf_data [NUM_BUFS];
    logic [1:0]          buf_mode [NUM_BUFS];
    logic [31:0]         buf_size [NUM_BUFS];
    logic [NUM_BUFS-1:0] buf_last, buf_busy, buf_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_BUFS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Per-mode geometry and buffer availability for the block being filled.
    always_comb begin
        dom        = domain_byte(mode_q);
        wpb        = 6'(rate_bytes(mode_q) / 8'(BPW));
        block_full = (widx == wpb - 6'd1);
        have_buf   = cur_alloc || !buf_busy[wr_ptr];
        target     = cur_alloc ? cur : wr_ptr;
        pad_idx    = 8'(32'(widx) * BPW);
        take_blk   = block_valid && block_ready;
        alloc      = (do_write || do_or) && !cur_alloc;
    end

    // Word preparation: optional byte swap, then mask tail bytes and insert
    // the domain byte when the message ends inside this word.
    always_comb begin
        swapped = data_in;
`ifdef LOAD_BYTE_SWAP_EN
        for (int unsigned b = 0; b < BPW; b++)
            swapped[8*b +: 8] = data_in[8*(BPW-1-b) +: 8];
`endif
        wr_word = swapped;
        if (remaining < 30'(BPW)) begin
            for (int unsigned b = 0; b < BPW; b++) begin
                if (b == 32'(remaining))
                    wr_word[8*b +: 8] = dom;
                else if (b > 32'(remaining))
                    wr_word[8*b +: 8] = 8'h00;
            end
        end
    end

    // FSM state register; armed keeps ready_out low until the first clock after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HDR0;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nx  = state;
        ready_out = 1'b0;
        do_write  = 1'b0;
        do_or     = 1'b0;
        blk_end   = 1'b0;
        msg_end   = 1'b0;
        hdr0_take = 1'b0;
        hdr1_take = 1'b0;
        case (state)
            ST_HDR0: begin
                ready_out = armed;
                if (valid_in && armed) begin
                    hdr0_take = 1'b1;
                    state_nx  = ST_HDR1;
                end
            end
            ST_HDR1: begin
                ready_out = armed;
                if (valid_in && armed) begin
                    hdr1_take = 1'b1;
                    state_nx  = (data_in[29:0] == 30'd0) ? ST_PAD : ST_LOAD;
                end
            end
            ST_LOAD: begin
                ready_out = have_buf;
                if (valid_in && have_buf) begin
                    do_write = 1'b1;
                    if (remaining < 30'(BPW)) begin
                        msg_end  = 1'b1;
                        blk_end  = 1'b1;
                        state_nx = ST_HDR0;
                    end else begin
                        blk_end = block_full;
                        if (remaining == 30'(BPW))
                            state_nx = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (have_buf) begin
                    do_or    = 1'b1;
                    msg_end  = 1'b1;
                    blk_end  = 1'b1;
                    state_nx = ST_HDR0;
                end
            end
            default: state_nx = ST_HDR0;
        endcase
    end

    // Header latches, byte/word counters, buffer allocation and commit pipeline.
    // Allocation happens on the first write into a block, so a freed buffer is
    // usable in the cycle right after its release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_SHAKE128;
            size_q      <= '0;
            remaining   <= '0;
            widx        <= '0;
            cur         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cur_alloc   <= 1'b0;
            commit_pend <= 1'b0;
            commit_idx  <= '0;
            commit_last <= 1'b0;
        end else begin
            if (hdr0_take)
                size_q <= data_in[31:0];
            if (hdr1_take) begin
                mode_q    <= mode_t'(data_in[31:30]);
                remaining <= data_in[29:0];
                widx      <= '0;
            end
            if (do_write) begin
                remaining <= (remaining > 30'(BPW)) ? remaining - 30'(BPW) : '0;
                widx      <= widx + 6'd1;
            end
            if (alloc) begin
                cur       <= wr_ptr;
                wr_ptr    <= ptr_inc(wr_ptr);
                cur_alloc <= 1'b1;
            end
            if (blk_end) begin
                cur_alloc <= 1'b0;
                widx      <= '0;
            end
            commit_pend <= blk_end;
            commit_idx  <= target;
            commit_last <= msg_end;
            if (take_blk)
                rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    for (genvar i = 0; i < NUM_BUFS; i++) begin : g_buf
        load_block_buf #(
            .W         (W),
            .RATE_BITS (RATE_MAX)
        ) u_buf (
            .clk     (clk),
            .rst     (rst),
            .alloc   (alloc && (target == PW'(i))),
            .mode_in (mode_q),
            .size_in (size_q),
            .wr_en   (do_write && (target == PW'(i))),
            .wr_idx  (widx),
            .wr_data (wr_word),
            .or_en   (do_or && (target == PW'(i))),
            .or_idx  (pad_idx),
            .or_byte (dom),
            .commit  (commit_pend && (commit_idx == PW'(i))),
            .last_in (commit_last),
            .clear   (take_blk && (rd_ptr == PW'(i))),
            .data    (buf_data[i]),
            .mode    (buf_mode[i]),
            .size    (buf_size[i]),
            .last    (buf_last[i]),
            .busy    (buf_busy[i]),
            .valid   (buf_valid[i])
        );
    end

    // Present the oldest committed buffer; outputs read zero while nothing is valid.
    always_comb begin
        block_valid = buf_valid[rd_ptr];
        block_out   = '0;
        block_last  = 1'b0;
        block_mode  = '0;
        output_size = '0;
        if (block_valid) begin
            block_out   = buf_data[rd_ptr];
            block_last  = buf_last[rd_ptr];
            block_mode  = buf_mode[rd_ptr];
            output_size = buf_size[rd_ptr];
        end
    end

endmodule

// File: tb/tb_load_stage_mr.sv
// Directed self-checking bench for load_stage_mr (W=64, NUM_BUFS=2).
module tb_load_stage_mr;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [63:0]   data_in = '0;
    logic          block_ready = 1'b0;
    logic          ready_out, block_valid, block_last;
    logic [1343:0] block_out;
    logic [1:0]    block_mode;
    logic [31:0]   output_size;

    int unsigned   total = 0;
    int unsigned   bad = 0;
    logic [1343:0] exp_blk;

    load_stage_mr #(
        .W        (64),
        .NUM_BUFS (2),
        .RATE_MAX (1344)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .ready_out   (ready_out),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_last  (block_last),
        .block_mode  (block_mode),
        .output_size (output_size)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] stored(input logic [63:0] w);
        logic [63:0] s;
        s = w;
`ifdef LOAD_BYTE_SWAP_EN
        for (int unsigned b = 0; b < 8; b++)
            s[8*b +: 8] = w[8*(7-b) +: 8];
`endif
        return s;
    endfunction

    function automatic logic [63:0] wpat(input int unsigned k);
        return {32'hC0DE0000 + k, 32'h12340000 + 3 * k};
    endfunction

    task automatic exp_word(input int unsigned idx, input logic [63:0] w, input int unsigned nbytes);
        logic [63:0] s;
        s = stored(w);
        for (int unsigned b = 0; b < nbytes; b++)
            exp_blk[(idx*8 + b)*8 +: 8] = s[8*b +: 8];
    endtask

    task automatic exp_or(input int unsigned pos, input logic [7:0] v);
        exp_blk[pos*8 +: 8] = exp_blk[pos*8 +: 8] | v;
    endtask

    task automatic build_exp(input int unsigned first, input int unsigned count);
        exp_blk = '0;
        for (int unsigned i = 0; i < count; i++)
            exp_word(i, wpat(first + i), 8);
    endtask

    // Present a word (called at a negedge); returns at the negedge after acceptance.
    task automatic send(input logic [63:0] w);
        int unsigned n = 0;
        valid_in = 1'b1;
        data_in  = w;
        while (ready_out !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready_out !== 1'b1)
            check("send_timeout", 64'(ready_out), 64'd1);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic hdr(input logic [31:0] size, input logic [1:0] mode, input logic [29:0] len);
        send({32'h0, size});
        send({32'hFFFF_FFFF, mode, len});
    endtask

    task automatic wait_valid(input string tag);
        int unsigned n = 0;
        while (block_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_valid", tag), 64'(block_valid), 64'd1);
    endtask

    task automatic take_block(input string tag, input logic last, input logic [1:0] mode,
                              input logic [31:0] size);
        wait_valid(tag);
        for (int unsigned k = 0; k < 21; k++)
            check($sformatf("%s_w%0d", tag, k), block_out[64*k +: 64], exp_blk[64*k +: 64]);
        check($sformatf("%s_last", tag), 64'(block_last), 64'(last));
        check($sformatf("%s_mode", tag), 64'(block_mode), 64'(mode));
        check($sformatf("%s_size", tag), 64'(output_size), 64'(size));
        block_ready = 1'b1;
        @(negedge clk);
        block_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b0_exp;

        // Reset state
        #1;
        check("rst_ready", 64'(ready_out), 64'd0);
        check("rst_valid", 64'(block_valid), 64'd0);
        check("rst_out", 64'(|block_out), 64'd0);
        check("rst_last", 64'(block_last), 64'd0);
        check("rst_size", 64'(output_size), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("hdr0_ready", 64'(ready_out), 64'd1);

        // Mode 00, L=0: single padding-only block
        hdr(32'd256, 2'b00, 30'd0);
        exp_blk = '0;
        exp_or(0, 8'h1F);
        exp_or(167, 8'h80);
        take_block("t1", 1'b1, 2'b00, 32'd256);

        // Mode 00, L=168: full data block then a padding-only block
        hdr(32'd512, 2'b00, 30'd168);
        for (int unsigned k = 0; k < 21; k++)
            send(wpat(k));
        build_exp(0, 21);
        take_block("t2a", 1'b0, 2'b00, 32'd512);
        exp_blk = '0;
        exp_or(0, 8'h1F);
        exp_or(167, 8'h80);
        take_block("t2b", 1'b1, 2'b00, 32'd512);

        // Mode 11, L=71: domain and final pad share byte 71
        hdr(32'd1024, 2'b11, 30'd71);
        exp_blk = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            send(wpat(100 + k));
            exp_word(k, wpat(100 + k), (k < 8) ? 8 : 7);
        end
        check("t3_lat0", 64'(block_valid), 64'd0);
        @(negedge clk);
        check("t3_lat1", 64'(block_valid), 64'd1);
        check("t3_b71", 64'(block_out[71*8 +: 8]), 64'h86);
        exp_or(71, 8'h06);
        exp_or(71, 8'h80);
        take_block("t3", 1'b1, 2'b11, 32'd1024);

        // Mode 01, L=16: word-aligned end needs a PAD cycle
        hdr(32'd256, 2'b01, 30'd16);
        exp_blk = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            send(wpat(200 + k));
            exp_word(k, wpat(200 + k), 8);
        end
        check("t4_pad_ready", 64'(ready_out), 64'd0);
        check("t4_lat0", 64'(block_valid), 64'd0);
        @(negedge clk);
        check("t4_lat1", 64'(block_valid), 64'd0);
        @(negedge clk);
        check("t4_lat2", 64'(block_valid), 64'd1);
        exp_or(16, 8'h1F);
        exp_or(135, 8'h80);
        take_block("t4", 1'b1, 2'b01, 32'd256);

        // Both buffers full with block_ready low: stall, then resume after one release
        hdr(32'd4000, 2'b00, 30'd400);
        for (int unsigned k = 0; k < 42; k++)
            send(wpat(k));
        valid_in = 1'b1;
        data_in  = wpat(42);
        @(negedge clk);
        check("t5_stall0", 64'(ready_out), 64'd0);
        check("t5_held", 64'(block_valid), 64'd1);
        @(negedge clk);
        check("t5_stall1", 64'(ready_out), 64'd0);
        build_exp(0, 21);
        take_block("t5a", 1'b0, 2'b00, 32'd4000);
        check("t5_resume", 64'(ready_out), 64'd1);
        for (int unsigned k = 42; k < 50; k++)
            send(wpat(k));
        build_exp(21, 21);
        take_block("t5b", 1'b0, 2'b00, 32'd4000);
        build_exp(42, 8);
        exp_or(64, 8'h1F);
        exp_or(167, 8'h80);
        take_block("t5c", 1'b1, 2'b00, 32'd4000);

        // Reset in the middle of LOAD, then a fresh message
        hdr(32'd64, 2'b00, 30'd100);
        for (int unsigned k = 0; k < 3; k++)
            send(wpat(300 + k));
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 64'(ready_out), 64'd0);
        check("t6_rst_valid", 64'(block_valid), 64'd0);
        @(negedge clk);
        check("t6_rst_ready2", 64'(ready_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready", 64'(ready_out), 64'd1);
        check("t6_nodrain", 64'(block_valid), 64'd0);
        hdr(32'd128, 2'b10, 30'd5);
        send(64'h0807060504030201);
        exp_blk = '0;
        exp_word(0, 64'h0807060504030201, 5);
        exp_or(5, 8'h06);
        exp_or(135, 8'h80);
`ifdef LOAD_BYTE_SWAP_EN
        b0_exp = 8'h08;
`else
        b0_exp = 8'h01;
`endif
        wait_valid("t6_pre");
        check("t6_byte0", 64'(block_out[7:0]), 64'(b0_exp));
        take_block("t6", 1'b1, 2'b10, 32'd128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
